// File: rtl/lut_rr_arbiter.sv
// Two-port round-robin arbiter in front of a 4x8 one-hot lookup table.
// Each transaction is grant (IDLE) -> registered read (READ) -> ack (RESP).
module lut_rr_arbiter #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              gnt_id
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_prio;
    logic [ADDR_W-1:0]   r_addr_q;
    logic                r_gnt_id;
    logic [DATA_W-1:0]   r_rdata;
    logic                w_grant;
    logic                w_win;
    logic [DATA_W-1:0]   w_entry;

    // Table contents are implicit: entry i is a single set bit at position i.
    assign w_entry = {{(DATA_W-1){1'b0}}, 1'b1} << r_addr_q;

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_win       = r_prio;
        case (r_state)
            IDLE: begin
                if (req0 || req1) begin
                    w_grant     = 1'b1;
                    w_state_nxt = READ;
                    // Pointer only matters on a tie; a lone requester always wins.
                    w_win       = (req0 && req1) ? r_prio : req1;
                end
            end
            READ:    w_state_nxt = RESP;
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_prio   <= 1'b0;
            r_addr_q <= '0;
            r_gnt_id <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_addr_q <= w_win ? addr1 : addr0;
                r_gnt_id <= w_win;
            end
            if (r_state == READ)
                r_rdata <= w_entry;
            // Hand priority to the other side after every completed grant.
            if (r_state == RESP)
                r_prio <= ~r_gnt_id;
        end
    end

    assign ack0   = (r_state == RESP) && !r_gnt_id;
    assign ack1   = (r_state == RESP) &&  r_gnt_id;
    assign rdata  = r_rdata;
    assign busy   = (r_state != IDLE);
    assign gnt_id = r_gnt_id;

endmodule

// File: tb/tb_lut_rr_arbiter.sv
// Directed bench for lut_rr_arbiter: reset, sweep, tie, contention,
// withdrawal and priority rotation scenarios with hand-computed results.
module tb_lut_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, req1;
    logic [1:0] addr0, addr1;
    logic       ack0, ack1;
    logic [7:0] rdata;
    logic       busy;
    logic       gnt_id;

    int checks   = 0;
    int failures = 0;

    lut_rr_arbiter #(.ADDR_W(2), .DATA_W(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req0   (req0),
        .addr0  (addr0),
        .req1   (req1),
        .addr1  (addr1),
        .ack0   (ack0),
        .ack1   (ack1),
        .rdata  (rdata),
        .busy   (busy),
        .gnt_id (gnt_id)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        addr0 = 2'd0;
        addr1 = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        int n;
        do_reset();
        checks++;
        if ({ack0, ack1, busy, gnt_id, rdata} !== 12'h000) begin
            failures++;
            $display("FAIL reset_state got=%h want=000", {ack0, ack1, busy, gnt_id, rdata});
        end
        // Leave rdata non-zero so the async clear is visible.
        req1 = 1'b1; addr1 = 2'd3;
        tick(); tick();
        req1 = 1'b0;
        tick();
        req0 = 1'b1; addr0 = 2'd1;
        tick();
        checks++;
        if (busy !== 1'b1 || rdata !== 8'h08) begin
            failures++;
            $display("FAIL reset_pre_read busy=%b rdata=%h want busy=1 rdata=08", busy, rdata);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({ack0, ack1, busy} !== 3'b000 || rdata !== 8'h00) begin
            failures++;
            $display("FAIL reset_async ack0=%b ack1=%b busy=%b rdata=%h want all 0",
                     ack0, ack1, busy, rdata);
        end
        @(posedge clk);
        #1;
        req0  = 1'b1;
        addr0 = 2'd2;
        rst_n = 1'b1;
        n = 0;
        while (ack0 !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (n != 2 || rdata !== 8'h04) begin
            failures++;
            $display("FAIL reset_recover edges=%0d rdata=%h want edges=2 rdata=04", n, rdata);
        end
        req0 = 1'b0;
        tick();
    endtask

    task automatic test_sweep();
        logic [7:0] exp_tab [4];
        exp_tab = '{8'h01, 8'h02, 8'h04, 8'h08};
        do_reset();
        for (int a = 0; a < 4; a++) begin
            req1  = 1'b1;
            addr1 = a[1:0];
            tick();
            checks++;
            if (ack1 !== 1'b0 || busy !== 1'b1 || gnt_id !== 1'b1) begin
                failures++;
                $display("FAIL sweep_read a=%0d ack1=%b busy=%b gnt=%b want 0 1 1",
                         a, ack1, busy, gnt_id);
            end
            tick();
            checks++;
            if (ack1 !== 1'b1 || ack0 !== 1'b0 || rdata !== exp_tab[a]) begin
                failures++;
                $display("FAIL sweep_ack a=%0d ack1=%b ack0=%b rdata=%h want 1 0 %h",
                         a, ack1, ack0, rdata, exp_tab[a]);
            end
            req1 = 1'b0;
            tick();
            checks++;
            if (busy !== 1'b0 || ack1 !== 1'b0 || rdata !== exp_tab[a]) begin
                failures++;
                $display("FAIL sweep_idle a=%0d busy=%b ack1=%b rdata=%h want 0 0 %h",
                         a, busy, ack1, rdata, exp_tab[a]);
            end
        end
    endtask

    task automatic test_tie();
        do_reset();
        req0 = 1'b1; addr0 = 2'd3;
        req1 = 1'b1; addr1 = 2'd1;
        tick();
        checks++;
        if (gnt_id !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL tie_grant gnt=%b busy=%b want 0 1", gnt_id, busy);
        end
        tick();
        checks++;
        if (ack0 !== 1'b1 || ack1 !== 1'b0 || rdata !== 8'h08) begin
            failures++;
            $display("FAIL tie_first ack0=%b ack1=%b rdata=%h want 1 0 08", ack0, ack1, rdata);
        end
        req0 = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (ack1 !== 1'b1 || ack0 !== 1'b0 || rdata !== 8'h02) begin
            failures++;
            $display("FAIL tie_second ack0=%b ack1=%b rdata=%h want 0 1 02", ack0, ack1, rdata);
        end
        req1 = 1'b0;
        tick();
    endtask

    task automatic test_contention();
        logic [1:0] exp_ack;
        logic [7:0] exp_rd;
        do_reset();
        req0 = 1'b1; addr0 = 2'd0;
        req1 = 1'b1; addr1 = 2'd2;
        for (int c = 1; c <= 12; c++) begin
            tick();
            exp_ack = 2'b00;
            if (c % 3 == 2)
                exp_ack = ((c / 3) % 2 == 0) ? 2'b01 : 2'b10;
            exp_rd = exp_ack[1] ? 8'h04 : 8'h01;
            checks++;
            if ({ack1, ack0} !== exp_ack || (exp_ack != 2'b00 && rdata !== exp_rd)) begin
                failures++;
                $display("FAIL contention c=%0d ack1ack0=%b rdata=%h want %b %h",
                         c, {ack1, ack0}, rdata, exp_ack, exp_rd);
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
    endtask

    task automatic test_withdraw();
        do_reset();
        req0 = 1'b1; addr0 = 2'd1;
        tick();
        addr0 = 2'd3;
        req0  = 1'b0;
        tick();
        checks++;
        if (ack0 !== 1'b1 || ack1 !== 1'b0 || rdata !== 8'h02) begin
            failures++;
            $display("FAIL withdraw_ack ack0=%b ack1=%b rdata=%h want 1 0 02", ack0, ack1, rdata);
        end
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || ack0 !== 1'b0 || rdata !== 8'h02) begin
            failures++;
            $display("FAIL withdraw_idle busy=%b ack0=%b rdata=%h want 0 0 02", busy, ack0, rdata);
        end
    endtask

    task automatic test_fairness();
        do_reset();
        req0 = 1'b1; addr0 = 2'd0;
        tick(); tick();
        checks++;
        if (ack0 !== 1'b1 || rdata !== 8'h01) begin
            failures++;
            $display("FAIL fair_solo ack0=%b rdata=%h want 1 01", ack0, rdata);
        end
        req0 = 1'b0;
        tick();
        req0 = 1'b1; addr0 = 2'd2;
        req1 = 1'b1; addr1 = 2'd3;
        tick();
        checks++;
        if (gnt_id !== 1'b1) begin
            failures++;
            $display("FAIL fair_grant gnt=%b want 1", gnt_id);
        end
        tick();
        checks++;
        if (ack1 !== 1'b1 || ack0 !== 1'b0 || rdata !== 8'h08) begin
            failures++;
            $display("FAIL fair_first ack0=%b ack1=%b rdata=%h want 0 1 08", ack0, ack1, rdata);
        end
        req1 = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (ack0 !== 1'b1 || ack1 !== 1'b0 || rdata !== 8'h04) begin
            failures++;
            $display("FAIL fair_second ack0=%b ack1=%b rdata=%h want 1 0 04", ack0, ack1, rdata);
        end
        req0 = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_tie();
        test_contention();
        test_withdraw();
        test_fairness();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
